// File: rtl/param_reg_file.sv
// Parameterised 3-read / 1-write register file with a sequential clear engine.
// Register 0 can be hardwired to zero (R0_ZERO). While the clear sequencer runs,
// external writes are rejected and flagged with a one-cycle wr_err pulse.
// Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle write data to any
// read port addressing the register being written.
module param_reg_file #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] rdAddrR1,
  input  logic [ADDR_W-1:0] rdAddrR2,
  input  logic [ADDR_W-1:0] rdAddrR3,
  output logic [DATA_W-1:0] rdDataR1,
  output logic [DATA_W-1:0] rdDataR2,
  output logic [DATA_W-1:0] rdDataR3,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                busy_q;
  logic                wr_err_q;
  logic [DATA_W-1:0]   regs_q [NumRegs];
  logic                wr_en;

  // Writes to a hardwired-zero register 0 are silently dropped, not flagged.
  always_comb begin
    wr_en = wr && !busy_q && !((R0_ZERO != 0) && (wrAddr == '0));
  end

  // Clear sequencer: one register per cycle from 0 up, single pass, no restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr && busy_q;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear engine owns the write port while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (busy_q) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_en && (addr == wrAddr)) begin
      val = wrData;
    end
`endif
    if ((R0_ZERO != 0) && (addr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  // Combinational read ports.
  always_comb begin
    rdDataR1 = read_port(rdAddrR1);
    rdDataR2 = read_port(rdAddrR2);
    rdDataR3 = read_port(rdAddrR3);
  end

  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed self-checking bench for param_reg_file (default parameters).
module tb_param_reg_file;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [3:0]  wrAddr;
  logic [15:0] wrData;
  logic        clr_req;
  logic [3:0]  rdAddrR1, rdAddrR2, rdAddrR3;
  logic [15:0] rdDataR1, rdDataR2, rdDataR3;
  logic        busy;
  logic        wr_err;

  int checks;
  int errors;
  int busy_cnt;
  int errp_cnt;
  int j;

  param_reg_file #(
    .DATA_W (16),
    .ADDR_W (4),
    .R0_ZERO(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .clr_req (clr_req),
    .rdAddrR1(rdAddrR1),
    .rdAddrR2(rdAddrR2),
    .rdAddrR3(rdAddrR3),
    .rdDataR1(rdDataR1),
    .rdDataR2(rdDataR2),
    .rdDataR3(rdDataR3),
    .busy    (busy),
    .wr_err  (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    wr = 1'b1; wrAddr = a; wrData = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rdAddrR1 = 4'(i);
      #1;
      check(tag, 32'(rdDataR1), 32'h0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; wr = 1'b0; wrAddr = '0; wrData = '0; clr_req = 1'b0;
    rdAddrR1 = '0; rdAddrR2 = '0; rdAddrR3 = '0;

    // Reset then read
    #2;
    check_all_zero("reset_zero_in_rst");
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_zero");
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_wr_err", 32'(wr_err), 32'h0);

    // Basic write/read
    do_write(4'd3, 16'hF033);
    do_write(4'd8, 16'h8888);
    rdAddrR1 = 4'd3; rdAddrR2 = 4'd8; rdAddrR3 = 4'd3;
    #1;
    check("basic_r1", 32'(rdDataR1), 32'hF033);
    check("basic_r2", 32'(rdDataR2), 32'h8888);
    check("basic_r3", 32'(rdDataR3), 32'hF033);
    rdAddrR2 = 4'd3;
    #1;
    check("same_addr_r2", 32'(rdDataR2), 32'hF033);

    // R0 hardwired (also exempt from bypass)
    rdAddrR1 = 4'd0;
    @(negedge clk);
    wr = 1'b1; wrAddr = 4'd0; wrData = 16'hFFFF;
    #1;
    check("r0_during_write", 32'(rdDataR1), 32'h0);
    @(negedge clk);
    wr = 1'b0;
    #1;
    check("r0_after_write", 32'(rdDataR1), 32'h0);
    check("r0_wr_err", 32'(wr_err), 32'h0);

    // Bypass
    rdAddrR2 = 4'd7;
    @(negedge clk);
    wr = 1'b1; wrAddr = 4'd7; wrData = 16'h00FF;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    check("bypass_same_cycle", 32'(rdDataR2), 32'h00FF);
`else
    check("bypass_same_cycle", 32'(rdDataR2), 32'h0000);
`endif
    @(negedge clk);
    wr = 1'b0;
    #1;
    check("bypass_after_edge", 32'(rdDataR2), 32'h00FF);

    // Clear sequence
    for (int i = 1; i < 16; i++) begin
      do_write(4'(i), 16'h6666);
    end
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    busy_cnt = 0; errp_cnt = 0; j = 0;
    while (busy && j < 40) begin
      busy_cnt++;
      if (wr_err) errp_cnt++;
      if (j == 3) check("wr_err_pulse", 32'(wr_err), 32'h1);
      if (j == 4) check("wr_err_drop", 32'(wr_err), 32'h0);
      if (j == 2) begin
        wr = 1'b1; wrAddr = 4'd5; wrData = 16'h1234;
      end else begin
        wr = 1'b0;
      end
      clr_req = (j == 7);
      if (j == 4) begin
        rdAddrR1 = 4'd3; rdAddrR2 = 4'd4; rdAddrR3 = 4'd5;
        #1;
        check("mid_clear_done", 32'(rdDataR1), 32'h0);
        check("mid_clear_old4", 32'(rdDataR2), 32'h6666);
        check("mid_clear_old5", 32'(rdDataR3), 32'h6666);
      end
      @(negedge clk);
      j++;
    end
    wr = 1'b0; clr_req = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("wr_err_count", 32'(errp_cnt), 32'd1);
    check("busy_after_clear", 32'(busy), 32'h0);
    check_all_zero("after_clear");

    // Simultaneous write and clear request
    @(negedge clk);
    wr = 1'b1; wrAddr = 4'd9; wrData = 16'hABCD; clr_req = 1'b1;
    @(negedge clk);
    wr = 1'b0; clr_req = 1'b0;
    rdAddrR1 = 4'd9;
    #1;
    check("simul_busy", 32'(busy), 32'h1);
    check("simul_written", 32'(rdDataR1), 32'hABCD);
    j = 0;
    while (busy && j < 40) begin
      @(negedge clk);
      j++;
    end
    #1;
    check("simul_done", 32'(busy), 32'h0);
    check("simul_cleared", 32'(rdDataR1), 32'h0);

    // Reset mid-clear
    do_write(4'd2, 16'h1111);
    rdAddrR1 = 4'd2;
    #1;
    check("pre_rst_val", 32'(rdDataR1), 32'h1111);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_async", 32'(busy), 32'h0);
    check("rst_wr_err", 32'(wr_err), 32'h0);
    rdAddrR1 = 4'd2;
    #1;
    check("rst_reg2_async", 32'(rdDataR1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("after_rst_mid_clear");
    check("after_rst_busy", 32'(busy), 32'h0);
    do_write(4'd2, 16'h0050);
    rdAddrR1 = 4'd2;
    #1;
    check("post_rst_write", 32'(rdDataR1), 32'h0050);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of every data word.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; register count is 2^ADDR_W.
REQ-003 Parameter R0_ZERO, default 1, SHALL hardwire register 0 to zero when 1, making it an ordinary register when 0.
REQ-004 Ports SHALL be as follows; clock and reset come first.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write enable.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- clr_req  in  1  one-cycle request to start a sequential clear.
- rdAddrR1 / rdAddrR2 / rdAddrR3  in  ADDR_W  read addresses.
- rdDataR1 / rdDataR2 / rdDataR3  out  DATA_W  combinational read data.
- busy  out  1  high while the clear sequencer runs.
- wr_err  out  1  registered one-cycle pulse when a write is rejected.

Function
REQ-005 A write SHALL update register wrAddr with wrData on the rising clk edge when wr=1 and busy=0.
REQ-006 When R0_ZERO=1, writes to address 0 SHALL be discarded without setting wr_err, and reads of address 0 SHALL return 0.
REQ-007 Each read port SHALL return the addressed register combinationally, with zero-cycle latency from the address.
REQ-008 All three read ports MAY address the same register at once, and SHALL then return identical data.
REQ-009 The sequencer SHALL have two states, IDLE and CLEAR; reset enters IDLE.
REQ-010 In IDLE, clr_req=1 on a rising edge SHALL enter CLEAR, load the internal counter cnt with 0 and set busy=1 in the next cycle.
REQ-011 In CLEAR, each cycle SHALL write 0 to register cnt and increment cnt.
REQ-012 After the edge that clears register 2^ADDR_W-1, the sequencer SHALL return to IDLE with busy=0, so busy is high for exactly 2^ADDR_W cycles.
REQ-013 The counter SHALL NOT wrap back into a second pass.
REQ-014 clr_req while busy=1 SHALL be ignored and SHALL NOT restart the count.
REQ-015 wr=1 while busy=1 SHALL leave the array unmodified and SHALL assert wr_err for exactly one cycle after that edge.
REQ-016 A simultaneous wr=1 and clr_req=1 in IDLE SHALL perform the write, then start CLEAR, and the written value SHALL also be cleared in turn.
REQ-017 While busy=1, reads SHALL return current array contents: registers already cleared read 0, the rest read their old values.

Reset
REQ-018 rst=1 SHALL, asynchronously and without waiting for clk, set all 2^ADDR_W registers to 0.
REQ-019 rst=1 SHALL also force the sequencer to IDLE, set cnt=0, busy=0 and wr_err=0.
REQ-020 Reset asserted mid-CLEAR SHALL abort the sequence; after deassertion the block is IDLE with all registers 0.
REQ-021 The first rising edge after rst deasserts SHALL accept writes and clr_req normally.

Configuration
REQ-022 The feature is controlled by the macro REGFILE_WR_BYPASS_EN.
REQ-023 With REGFILE_WR_BYPASS_EN defined: when wr=1, busy=0, and a read address equals wrAddr, that port SHALL return wrData in the same cycle. This does not apply to address 0 when R0_ZERO=1.
REQ-024 Without REGFILE_WR_BYPASS_EN: that port SHALL return the pre-write contents, and the new value SHALL be visible from the cycle after the edge.

Verification
REQ-025 Reset then read: assert rst, release, read addresses 0..15 on R1 -> all 0x0000, busy=0, wr_err=0.
REQ-026 Basic write/read: write 0xF033 to address 3 and 0x8888 to address 8, then set R1=3, R2=8, R3=3 -> 0xF033, 0x8888, 0xF033.
REQ-027 R0 hardwired: with R0_ZERO=1, write 0xFFFF to address 0 -> R1 reads 0x0000, wr_err=0.
REQ-028 Clear sequence: fill addresses 1..15 with 0x6666, pulse clr_req -> busy high for exactly 16 cycles. A write to address 5 during busy -> wr_err pulses for 1 cycle. Afterwards all registers read 0.
REQ-029 Bypass: write 0x00FF to address 7 while R2=7 in the same cycle -> R2 shows 0x00FF before the edge when REGFILE_WR_BYPASS_EN is defined, and the old value otherwise.
REQ-030 Reset mid-clear: assert rst asynchronously at clear cycle 6 -> busy drops immediately. After release all registers read 0, and a subsequent write to address 2 of 0x0050 reads back 0x0050.
